// File: rtl/gcd_lcm_pkg.sv
// gcd_lcm_pkg: shared types and constants for the GCD/LCM execution unit.
//   gcd_lcm_state_t : sequencer states (IDLE, GSHIFT, GLOOP, DIV, MUL, DONE)
//   OP_GCD / OP_LCM : op-select encodings (funct3[0])
//   MODE_DIV/MODE_MUL : divide/multiply engine mode encodings
//   cnt_width()     : bits needed to count 0..w-1
//   K_W             : width of the common-power-of-two shift counter k at the default width
package gcd_lcm_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GSHIFT = 3'd1,
    GLOOP  = 3'd2,
    DIV    = 3'd3,
    MUL    = 3'd4,
    DONE   = 3'd5
  } gcd_lcm_state_t;

  localparam logic OP_GCD   = 1'b0;
  localparam logic OP_LCM   = 1'b1;

  localparam logic MODE_DIV = 1'b0;
  localparam logic MODE_MUL = 1'b1;

  localparam int DEF_WIDTH = 32;

  // Bits needed to hold any value 0..w-1 (never less than one bit).
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

  // Both operands are non-zero whenever k counts, so k never exceeds WIDTH-1.
  localparam int K_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/gcd_lcm_divmul.sv
// gcd_lcm_divmul: shared iterative divide / multiply engine.
//   One shift register (sh_r), one accumulator (acc_r) and a single
//   adder/subtractor. Runs exactly WIDTH step cycles after a go pulse.
//   MODE_DIV : restoring divide, load_val / step_val, quotient MSB first.
//   MODE_MUL : shift-add multiply, load_val * step_val, multiplier LSB first.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   go, mode     : load operands and start a run in the given mode
//   load_val     : dividend (DIV) or multiplicand (MUL), sampled on go
//   step_val     : divisor (DIV) or multiplier (MUL), held during the run
//   fin          : high during the last step cycle
//   res          : value the result register takes at the end of this step
//                  (quotient zero-extended in DIV, product in MUL)
module gcd_lcm_divmul
  import gcd_lcm_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int PW    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             go,
  input  logic             mode,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] step_val,
  output logic             fin,
  output logic [PW-1:0]    res
);

  localparam int CW = cnt_width(WIDTH);

  logic [PW-1:0]    sh_r;
  logic [PW-1:0]    acc_r;
  logic [CW-1:0]    cnt_r;
  logic             run_r;
  logic             mode_r;

  logic [WIDTH:0]   trial_s;
  logic [PW:0]      x_op_s;
  logic [PW:0]      y_op_s;
  logic             sub_s;
  logic [PW+1:0]    sum_s;
  logic             ge_s;
  logic [PW-1:0]    sh_nx_s;
  logic [PW-1:0]    acc_nx_s;
  logic             unused_s;

  // Partial remainder shifted left with the next dividend bit.
  assign trial_s = {acc_r[WIDTH-1:0], sh_r[WIDTH-1]};

  // Adder operand selection: subtract divisor in DIV, add shifted multiplicand in MUL.
  always_comb begin
    if (mode_r == MODE_DIV) begin
      x_op_s = (PW+1)'(trial_s);
      y_op_s = (PW+1)'(step_val);
      sub_s  = 1'b1;
    end else begin
      x_op_s = {1'b0, acc_r};
      y_op_s = step_val[cnt_r] ? {1'b0, sh_r} : {(PW+1){1'b0}};
      sub_s  = 1'b0;
    end
  end

  // Carry out of the extra top bit is set exactly when trial >= divisor.
  assign sum_s    = {1'b0, x_op_s} + {1'b0, (sub_s ? ~y_op_s : y_op_s)} + (PW+2)'(sub_s);
  assign ge_s     = sum_s[PW+1];
  assign unused_s = sum_s[PW];

  // Next shift-register / accumulator values for one step.
  always_comb begin
    if (mode_r == MODE_DIV) begin
      acc_nx_s = ge_s ? PW'(sum_s[WIDTH-1:0]) : PW'(trial_s[WIDTH-1:0]);
      sh_nx_s  = {sh_r[PW-2:0], ge_s};
    end else begin
      acc_nx_s = sum_s[PW-1:0];
      sh_nx_s  = {sh_r[PW-2:0], 1'b0};
    end
  end

  assign res = (mode_r == MODE_DIV) ? PW'(sh_nx_s[WIDTH-1:0]) : acc_nx_s;
  assign fin = run_r && (cnt_r == CW'(WIDTH - 1));

  // Engine state: go reloads (even on a run's last step), otherwise step while running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_r   <= {PW{1'b0}};
      acc_r  <= {PW{1'b0}};
      cnt_r  <= {CW{1'b0}};
      run_r  <= 1'b0;
      mode_r <= MODE_DIV;
    end else if (go) begin
      sh_r   <= PW'(load_val);
      acc_r  <= {PW{1'b0}};
      cnt_r  <= {CW{1'b0}};
      run_r  <= 1'b1;
      mode_r <= mode;
    end else if (run_r) begin
      sh_r  <= sh_nx_s;
      acc_r <= acc_nx_s;
      cnt_r <= cnt_r + CW'(1);
      if (fin) begin
        run_r <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/gcd_lcm_seq.sv
// gcd_lcm_seq: multi-cycle GCD/LCM unit for the core's custom-instruction slot.
//   GCD by binary (Stein) iteration; LCM = (a / gcd) * b via gcd_lcm_divmul.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : request, accepted only in IDLE (not queued otherwise)
//   op           : 0 = GCD, 1 = LCM
//   a, b         : unsigned operands
//   result       : GCD or low WIDTH bits of LCM, held until the next accepted start
//   busy         : high from the cycle after accept through DONE
//   done         : one-cycle pulse, result valid
//   stall        : start | busy
//   ovf          : (only with GCD_LCM_OVF_EN) LCM product exceeded WIDTH bits
// Optional feature macro: GCD_LCM_OVF_EN.
module gcd_lcm_seq
  import gcd_lcm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             stall
`ifdef GCD_LCM_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int KW = cnt_width(WIDTH);
`ifdef GCD_LCM_OVF_EN
  localparam int PW = 2 * WIDTH;
`else
  localparam int PW = WIDTH;
`endif
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  gcd_lcm_state_t   state_r, state_nx;
  logic [WIDTH-1:0] x_r, x_nx, y_r, y_nx;
  logic [WIDTH-1:0] ra_r, ra_nx, rb_r, rb_nx;
  logic             rop_r, rop_nx;
  logic [KW-1:0]    k_r, k_nx;
  logic [WIDTH-1:0] q_r, q_nx;
  logic [WIDTH-1:0] result_r, result_nx;
  logic             busy_r, busy_nx, done_r, done_nx;
`ifdef GCD_LCM_OVF_EN
  logic             ovf_r, ovf_nx;
`endif

  logic [WIDTH-1:0] g_s;
  logic             go_s, mode_s, fin_s;
  logic [WIDTH-1:0] load_val_s, step_val_s;
  logic [PW-1:0]    res_s;

  assign g_s = (x_r | y_r) << k_r;

  // Engine operands: the MUL multiplicand is loaded on the last DIV cycle.
  assign load_val_s = (state_r == DIV) ? rb_r : ra_r;
  assign step_val_s = (state_r == MUL) ? q_r : x_r;

  gcd_lcm_divmul #(
    .WIDTH(WIDTH),
    .PW   (PW)
  ) u_divmul (
    .clk     (clk),
    .reset_n (reset_n),
    .go      (go_s),
    .mode    (mode_s),
    .load_val(load_val_s),
    .step_val(step_val_s),
    .fin     (fin_s),
    .res     (res_s)
  );

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_nx  = state_r;
    x_nx      = x_r;
    y_nx      = y_r;
    ra_nx     = ra_r;
    rb_nx     = rb_r;
    rop_nx    = rop_r;
    k_nx      = k_r;
    q_nx      = q_r;
    result_nx = result_r;
    go_s      = 1'b0;
    mode_s    = MODE_DIV;
`ifdef GCD_LCM_OVF_EN
    ovf_nx    = ovf_r;
`endif
    case (state_r)
      IDLE: begin
        if (start) begin
          x_nx   = a;
          y_nx   = b;
          ra_nx  = a;
          rb_nx  = b;
          rop_nx = op;
          k_nx   = {KW{1'b0}};
`ifdef GCD_LCM_OVF_EN
          ovf_nx = 1'b0;
`endif
          if ((a == ZERO) || (b == ZERO)) begin
            result_nx = (op == OP_LCM) ? ZERO : (a | b);
            state_nx  = DONE;
          end else begin
            state_nx  = GSHIFT;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      GSHIFT: begin
        // Strip common factors of two; k remembers how many.
        if (!x_r[0] && !y_r[0]) begin
          x_nx = x_r >> 1;
          y_nx = y_r >> 1;
          k_nx = k_r + KW'(1);
        end else begin
          state_nx = GLOOP;
        end
      end
      GLOOP: begin
        if ((x_r == ZERO) || (y_r == ZERO)) begin
          if (rop_r == OP_GCD) begin
            result_nx = g_s;
            state_nx  = DONE;
          end else begin
            // x now carries the gcd as the divisor for the DIV phase.
            x_nx     = g_s;
            go_s     = 1'b1;
            mode_s   = MODE_DIV;
            state_nx = DIV;
          end
        end else if (!x_r[0]) begin
          x_nx = x_r >> 1;
        end else if (!y_r[0]) begin
          y_nx = y_r >> 1;
        end else if (x_r >= y_r) begin
          x_nx = x_r - y_r;
        end else begin
          y_nx = y_r - x_r;
        end
      end
      DIV: begin
        if (fin_s) begin
          q_nx     = res_s[WIDTH-1:0];
          go_s     = 1'b1;
          mode_s   = MODE_MUL;
          state_nx = MUL;
        end else begin
          state_nx = DIV;
        end
      end
      MUL: begin
        mode_s = MODE_MUL;
        if (fin_s) begin
          result_nx = res_s[WIDTH-1:0];
`ifdef GCD_LCM_OVF_EN
          ovf_nx    = |res_s[PW-1:WIDTH];
`endif
          state_nx  = DONE;
        end else begin
          state_nx = MUL;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    busy_nx = (state_nx != IDLE);
    done_nx = (state_nx == DONE);
  end

  // Sequencer state, datapath and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      x_r      <= ZERO;
      y_r      <= ZERO;
      ra_r     <= ZERO;
      rb_r     <= ZERO;
      rop_r    <= OP_GCD;
      k_r      <= {KW{1'b0}};
      q_r      <= ZERO;
      result_r <= ZERO;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
`ifdef GCD_LCM_OVF_EN
      ovf_r    <= 1'b0;
`endif
    end else begin
      state_r  <= state_nx;
      x_r      <= x_nx;
      y_r      <= y_nx;
      ra_r     <= ra_nx;
      rb_r     <= rb_nx;
      rop_r    <= rop_nx;
      k_r      <= k_nx;
      q_r      <= q_nx;
      result_r <= result_nx;
      busy_r   <= busy_nx;
      done_r   <= done_nx;
`ifdef GCD_LCM_OVF_EN
      ovf_r    <= ovf_nx;
`endif
    end
  end

  assign result = result_r;
  assign busy   = busy_r;
  assign done   = done_r;
  assign stall  = start | busy_r;
`ifdef GCD_LCM_OVF_EN
  assign ovf    = ovf_r;
`endif

endmodule

// File: tb/tb_gcd_lcm_seq.sv
// tb_gcd_lcm_seq: directed vectors with a scoreboard. The driver pushes the
// hand-computed expected result for each request; a monitor pops and compares
// on every done pulse.
module tb_gcd_lcm_seq;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;
  logic        busy;
  logic        done;
  logic        stall;
`ifdef GCD_LCM_OVF_EN
  logic        ovf;
`endif

  gcd_lcm_seq #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .result (result),
    .busy   (busy),
    .done   (done),
    .stall  (stall)
`ifdef GCD_LCM_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
    int          lat;
    bit          exact;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[8];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_done   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n && done) begin
      n_done++;
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: result=0x%08h with no request outstanding", result);
      end else begin
        mon_e = sb.pop_front();
        check("result", result, mon_e.res);
`ifdef GCD_LCM_OVF_EN
        check("ovf", {31'd0, ovf}, {31'd0, mon_e.ovf});
`endif
      end
    end
  end

  task automatic run_op(input logic o, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] er, input logic eo, input int max_lat, input bit exact);
    int cyc;
    bit seen;
    sb.push_back({er, eo});
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    cyc   = 0;
    seen  = 1'b0;
    while (!seen && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    n_checks++;
    if (!seen || (exact ? (cyc != max_lat) : (cyc > max_lat))) begin
      n_errors++;
      $display("FAIL latency op=%0d a=0x%08h b=0x%08h: got %0d cycles (done seen=%0d), required %s%0d",
               o, av, bv, cyc, seen, exact ? "" : "<=", max_lat);
    end
    @(negedge clk);
    check("busy_after_done", {31'd0, busy}, 32'd0);
    check("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  cyc;
    bit  seen;
    int  done_before;

    vecs[0] = '{1'b0, 32'd48,   32'd18,  32'd6,  1'b0, 97,  1'b0};
    vecs[1] = '{1'b1, 32'd4,    32'd6,   32'd12, 1'b0, 161, 1'b0};
    vecs[2] = '{1'b0, 32'd0,    32'd7,   32'd7,  1'b0, 1,   1'b1};
    vecs[3] = '{1'b1, 32'd0,    32'd7,   32'd0,  1'b0, 1,   1'b1};
    vecs[4] = '{1'b0, 32'd0,    32'd0,   32'd0,  1'b0, 1,   1'b1};
    vecs[5] = '{1'b0, 32'd7,    32'd0,   32'd7,  1'b0, 1,   1'b1};
    vecs[6] = '{1'b0, 32'd1071, 32'd462, 32'd21, 1'b0, 97,  1'b0};
    vecs[7] = '{1'b1, 32'd21,   32'd6,   32'd42, 1'b0, 161, 1'b0};

    reset_n = 1'b0;
    start   = 1'b0;
    op      = 1'b0;
    a       = 32'd0;
    b       = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_result", result, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_stall", {31'd0, stall}, 32'd0);
`ifdef GCD_LCM_OVF_EN
    check("reset_ovf", {31'd0, ovf}, 32'd0);
`endif
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ovf, vecs[i].lat, vecs[i].exact);
    end

    // Second start pulse while busy must be ignored (GCD(100,75)=25 must not appear).
    done_before = n_done;
    sb.push_back({32'd6, 1'b0});
    @(negedge clk);
    start = 1'b1;
    op    = 1'b0;
    a     = 32'd48;
    b     = 32'd18;
    cyc   = 0;
    seen  = 1'b0;
    while (!seen && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 5) begin
        start = 1'b1;
        a     = 32'd100;
        b     = 32'd75;
      end else begin
        start = 1'b0;
      end
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check("ignored_start_done_seen", {31'd0, seen}, 32'd1);
    repeat (120) @(negedge clk);
    check("ignored_start_done_count", n_done - done_before, 32'd1);
    check("ignored_start_result_held", result, 32'd6);

    // Reset during the MUL phase of LCM(12,18): abort with no done pulse.
    done_before = n_done;
    @(negedge clk);
    start = 1'b1;
    op    = 1'b1;
    a     = 32'd12;
    b     = 32'd18;
    repeat (55) @(negedge clk);
    check("busy_before_abort", {31'd0, busy}, 32'd1);
    start = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (100) @(negedge clk);
    check("abort_no_done", n_done - done_before, 32'd0);
    run_op(1'b1, 32'd12, 32'd18, 32'd36, 1'b0, 161, 1'b0);

    // gcd = 1, quotient 0xFFFFFFFF, product overflows WIDTH bits.
    run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0002, 1'b1, 161, 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
